// File: rtl/zap_tlb_walker.sv
// rtl/zap_tlb_walker.sv - page-table walk sequencer: L1/L2 descriptor fetch, TLB write or fault report
module zap_tlb_walker #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd256
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_walk,
    input  logic [31:0] i_va,
    input  logic [17:0] i_baddr,
    input  logic        i_flush,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic [31:0] o_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack,
    input  logic        i_wb_err,
    output logic [3:0]  o_tlb_wen,
    output logic [31:0] o_tlb_va,
    output logic [31:0] o_tlb_l1,
    output logic [31:0] o_tlb_l2,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_fault,
    output logic [7:0]  o_fsr,
    output logic [31:0] o_far
);
    typedef enum logic [2:0] {S_IDLE, S_L1, S_L2, S_WRITE, S_FAULT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] cap_va;
    logic [31:0] l1_desc;
    logic [31:0] l2_desc;
    logic [31:0] fetch_adr;
    logic [31:0] wdog;
    logic [3:0]  wen_sel;
    logic [7:0]  fsr;
    logic        fine_table;
    logic        l2_gap;
    logic        flushed;
    logic        cyc;
    logic        timeout;
    logic        bus_err;
    logic        bus_ack;
    logic        abort;

    // L2 spends its first cycle with the bus idle so cyc drops between fetches
    assign cyc     = (state == S_L1) || ((state == S_L2) && !l2_gap);
    assign timeout = (TIMEOUT_CYCLES != 32'd0) && cyc && !i_wb_ack && !i_wb_err
                     && (wdog == TIMEOUT_CYCLES - 32'd1);
    assign bus_err = cyc && (i_wb_err || timeout);
    assign bus_ack = cyc && i_wb_ack && !i_wb_err;
    assign abort   = flushed || i_flush;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (i_walk && !i_flush) state_nxt = S_L1;
            end
            S_L1: begin
                if (bus_err) begin
                    state_nxt = abort ? S_IDLE : S_FAULT;
                end else if (bus_ack) begin
                    if (abort)                        state_nxt = S_IDLE;
                    else if (i_wb_dat[1:0] == 2'b00)  state_nxt = S_FAULT;
                    else if (i_wb_dat[1:0] == 2'b10)  state_nxt = S_WRITE;
                    else                              state_nxt = S_L2;
                end
            end
            S_L2: begin
                if (l2_gap) begin
                    state_nxt = abort ? S_IDLE : S_L2;
                end else if (bus_err) begin
                    state_nxt = abort ? S_IDLE : S_FAULT;
                end else if (bus_ack) begin
                    if (abort)                                      state_nxt = S_IDLE;
                    else if (i_wb_dat[1:0] == 2'b00)                state_nxt = S_FAULT;
                    else if ((i_wb_dat[1:0] == 2'b11) && !fine_table) state_nxt = S_FAULT;
                    else                                            state_nxt = S_WRITE;
                end
            end
            S_WRITE: state_nxt = S_IDLE;
            S_FAULT: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_wb_cyc  = cyc;
        o_wb_stb  = cyc;
        o_wb_adr  = fetch_adr;
        o_tlb_wen = 4'b0000;
        o_tlb_va  = cap_va;
        o_tlb_l1  = l1_desc;
        o_tlb_l2  = l2_desc;
        o_busy    = (state != S_IDLE);
        o_done    = 1'b0;
        o_fault   = 1'b0;
        o_fsr     = fsr;
        o_far     = cap_va;
        if ((state == S_WRITE) && !i_flush) begin
            o_tlb_wen = wen_sel;
            o_done    = 1'b1;
        end
        if ((state == S_FAULT) && !i_flush) begin
            o_done  = 1'b1;
            o_fault = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cap_va     <= 32'd0;
            l1_desc    <= 32'd0;
            l2_desc    <= 32'd0;
            fetch_adr  <= 32'd0;
            wdog       <= 32'd0;
            wen_sel    <= 4'b0000;
            fsr        <= 8'h00;
            fine_table <= 1'b0;
            l2_gap     <= 1'b0;
            flushed    <= 1'b0;
        end else begin
            l2_gap <= (state == S_L1) && (state_nxt == S_L2);
            wdog   <= (cyc && !i_wb_ack && !i_wb_err) ? wdog + 32'd1 : 32'd0;

            if (state == S_IDLE)  flushed <= 1'b0;
            else if (i_flush)     flushed <= 1'b1;

            if ((state == S_IDLE) && i_walk && !i_flush) begin
                cap_va    <= i_va;
                fetch_adr <= {i_baddr, i_va[31:20], 2'b00};
                l1_desc   <= 32'd0;
                l2_desc   <= 32'd0;
                wen_sel   <= 4'b0000;
                fsr       <= 8'h00;
            end

            if (state == S_L1) begin
                if (bus_err) begin
                    fsr <= 8'h0C;
                end else if (bus_ack) begin
                    l1_desc    <= i_wb_dat;
                    fine_table <= (i_wb_dat[1:0] == 2'b11);
                    fetch_adr  <= (i_wb_dat[1:0] == 2'b11)
                                  ? {i_wb_dat[31:12], cap_va[19:10], 2'b00}
                                  : {i_wb_dat[31:10], cap_va[19:12], 2'b00};
                    if (i_wb_dat[1:0] == 2'b00) fsr     <= 8'h05;
                    if (i_wb_dat[1:0] == 2'b10) wen_sel <= 4'b0100;
                end
            end

            if (state == S_L2) begin
                if (bus_err) begin
                    fsr <= {l1_desc[8:5], 4'hE};
                end else if (bus_ack) begin
                    l2_desc <= i_wb_dat;
                    case (i_wb_dat[1:0])
                        2'b01:   wen_sel <= 4'b0010;
                        2'b10:   wen_sel <= 4'b0001;
                        2'b11: begin
                            if (fine_table) wen_sel <= 4'b1000;
                            else            fsr     <= {l1_desc[8:5], 4'h7};
                        end
                        default: fsr <= {l1_desc[8:5], 4'h7};
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_zap_tlb_walker.sv
// tb/tb_zap_tlb_walker.sv - directed vector bench for zap_tlb_walker
module tb_zap_tlb_walker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        walk = 1'b0;
    logic [31:0] va = 32'd0;
    logic [17:0] baddr = 18'd0;
    logic        flush = 1'b0;
    logic        cyc, stb;
    logic [31:0] adr;
    logic [31:0] dat = 32'd0;
    logic        ack = 1'b0;
    logic        err = 1'b0;
    logic [3:0]  wen;
    logic [31:0] tva, tl1, tl2, far;
    logic        busy, done, fault;
    logic [7:0]  fsr;

    int compared = 0;
    int mismatched = 0;
    int overlap = 0;

    zap_tlb_walker #(.TIMEOUT_CYCLES(32'd16)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_walk(walk), .i_va(va), .i_baddr(baddr),
        .i_flush(flush), .o_wb_cyc(cyc), .o_wb_stb(stb), .o_wb_adr(adr),
        .i_wb_dat(dat), .i_wb_ack(ack), .i_wb_err(err), .o_tlb_wen(wen),
        .o_tlb_va(tva), .o_tlb_l1(tl1), .o_tlb_l2(tl2), .o_busy(busy),
        .o_done(done), .o_fault(fault), .o_fsr(fsr), .o_far(far)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && cyc && ((wen != 4'b0000) || done)) overlap++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    // mode: 0 ack, 1 err, 2 silent (watchdog), 3 ack+err together
    typedef struct {
        string       name;
        logic [17:0] baddr;
        logic [31:0] va;
        logic [31:0] l1d;
        int          l1m;
        int          l1lat;
        logic [31:0] adr1;
        bit          has_l2;
        logic [31:0] l2d;
        int          l2m;
        int          l2lat;
        logic [31:0] adr2;
        logic [3:0]  wen;
        bit          flt;
        logic [7:0]  fsr;
        logic [31:0] l2o;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // returns at the negedge of the cycle after the bus event
    task automatic respond(input string nm, input int mode, input int lat,
                           input logic [31:0] d, input logic [31:0] exp_adr);
        if (mode == 2) begin
            repeat (16) @(negedge clk);
        end else begin
            for (int i = 1; i < lat; i++) @(negedge clk);
            chk({nm, "_hold_cyc"}, {31'd0, cyc & stb}, 32'd1);
            chk({nm, "_hold_adr"}, adr, exp_adr);
            dat = d;
            ack = (mode == 0) || (mode == 3);
            err = (mode == 1) || (mode == 3);
            @(negedge clk);
            ack = 1'b0;
            err = 1'b0;
        end
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        baddr = v.baddr;
        va    = v.va;
        walk  = 1'b1;
        @(negedge clk);
        walk = 1'b0;
        chk({v.name, "_cyc1"}, {31'd0, cyc}, 32'd1);
        chk({v.name, "_adr1"}, adr, v.adr1);
        respond({v.name, "_l1"}, v.l1m, v.l1lat, v.l1d, v.adr1);
        if (v.has_l2) begin
            chk({v.name, "_gap"}, {31'd0, cyc}, 32'd0);
            @(negedge clk);
            chk({v.name, "_cyc2"}, {31'd0, cyc}, 32'd1);
            chk({v.name, "_adr2"}, adr, v.adr2);
            respond({v.name, "_l2"}, v.l2m, v.l2lat, v.l2d, v.adr2);
        end
        chk({v.name, "_done"}, {31'd0, done}, 32'd1);
        chk({v.name, "_fault"}, {31'd0, fault}, {31'd0, v.flt});
        chk({v.name, "_wen"}, {28'd0, wen}, v.flt ? 32'd0 : {28'd0, v.wen});
        if (v.flt) begin
            chk({v.name, "_fsr"}, {24'd0, fsr}, {24'd0, v.fsr});
            chk({v.name, "_far"}, far, v.va);
        end else begin
            chk({v.name, "_tlb_va"}, tva, v.va);
            chk({v.name, "_tlb_l1"}, tl1, v.l1d);
            chk({v.name, "_tlb_l2"}, tl2, v.l2o);
        end
        @(negedge clk);
        chk({v.name, "_done_clr"}, {31'd0, done}, 32'd0);
        chk({v.name, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        //        name        baddr    va            l1d           l1m lat adr1          l2? l2d           l2m lat adr2          wen      flt fsr    l2o
        vecs[0]  = '{"section",  18'h10, 32'h1234_5678, 32'h8000_0C02, 0, 1, 32'h0004_048C, 0, 32'h0,         0, 0, 32'h0,         4'b0100, 0, 8'h00, 32'h0};
        vecs[1]  = '{"small",    18'h10, 32'h0003_4ABC, 32'h0010_0021, 0, 2, 32'h0004_0000, 1, 32'h5555_5FFE, 0, 3, 32'h0010_00D0, 4'b0001, 0, 8'h00, 32'h5555_5FFE};
        vecs[2]  = '{"l2_zero",  18'h10, 32'h0003_4ABC, 32'h0010_0021, 0, 1, 32'h0004_0000, 1, 32'h0,         0, 1, 32'h0010_00D0, 4'b0000, 1, 8'h17, 32'h0};
        vecs[3]  = '{"l1_err",   18'h10, 32'h1234_5678, 32'h0,         1, 2, 32'h0004_048C, 0, 32'h0,         0, 0, 32'h0,         4'b0000, 1, 8'h0C, 32'h0};
        vecs[4]  = '{"l2_tmo",   18'h10, 32'h0003_4ABC, 32'h0010_0021, 0, 1, 32'h0004_0000, 1, 32'h0,         2, 0, 32'h0010_00D0, 4'b0000, 1, 8'h1E, 32'h0};
        vecs[5]  = '{"fine",     18'h10, 32'h0003_4ABC, 32'h0020_0003, 0, 1, 32'h0004_0000, 1, 32'hABCD_0003, 0, 2, 32'h0020_0348, 4'b1000, 0, 8'h00, 32'hABCD_0003};
        vecs[6]  = '{"large",    18'h10, 32'h0003_4ABC, 32'h0010_0021, 0, 1, 32'h0004_0000, 1, 32'h1234_0001, 0, 1, 32'h0010_00D0, 4'b0010, 0, 8'h00, 32'h1234_0001};
        vecs[7]  = '{"coarse11", 18'h10, 32'h0003_4ABC, 32'h0010_01E1, 0, 1, 32'h0004_0000, 1, 32'h0000_0003, 0, 1, 32'h0010_00D0, 4'b0000, 1, 8'hF7, 32'h0};
        vecs[8]  = '{"l1_inval", 18'h10, 32'h1234_5678, 32'h0,         0, 3, 32'h0004_048C, 0, 32'h0,         0, 0, 32'h0,         4'b0000, 1, 8'h05, 32'h0};
        vecs[9]  = '{"l1_ackerr",18'h10, 32'h1234_5678, 32'h8000_0C02, 3, 1, 32'h0004_048C, 0, 32'h0,         0, 0, 32'h0,         4'b0000, 1, 8'h0C, 32'h0};
        vecs[10] = '{"l2_ackerr",18'h10, 32'h0003_4ABC, 32'h0010_01E1, 0, 1, 32'h0004_0000, 1, 32'h5555_5FFE, 3, 2, 32'h0010_00D0, 4'b0000, 1, 8'hFE, 32'h0};
        vecs[11] = '{"l2_err",   18'h3,  32'hFFF0_0000, 32'h0010_0021, 0, 1, 32'h0000_FFFC, 1, 32'h0,         1, 1, 32'h0010_0000, 4'b0000, 1, 8'h1E, 32'h0};

        #3;
        chk("rst_cyc", {31'd0, cyc}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {30'd0, done, fault}, 32'd0);
        chk("rst_wen", {28'd0, wen}, 32'd0);
        chk("rst_adr", adr, 32'd0);
        chk("rst_fsr_far", {24'd0, fsr} | far, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // flush while the L1 fetch is outstanding
        @(negedge clk);
        baddr = 18'h10; va = 32'h1234_5678; walk = 1'b1;
        @(negedge clk);
        walk = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_l1_held", {31'd0, cyc}, 32'd1);
        chk("flush_l1_nodone", {31'd0, done}, 32'd0);
        @(negedge clk);
        dat = 32'h8000_0C02; ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        chk("flush_cyc_drop", {31'd0, cyc}, 32'd0);
        chk("flush_idle", {31'd0, busy}, 32'd0);
        chk("flush_silent", {27'd0, done, wen}, 32'd0);
        walk = 1'b1;
        @(negedge clk);
        walk = 1'b0;
        chk("flush_rewalk_cyc", {31'd0, cyc}, 32'd1);
        respond("flush_rewalk", 0, 1, 32'h8000_0C02, 32'h0004_048C);
        chk("flush_rewalk_wen", {28'd0, wen}, 32'h4);
        chk("flush_rewalk_done", {31'd0, done}, 32'd1);

        // flush landing on the WRITE cycle suppresses the write
        @(negedge clk);
        walk = 1'b1;
        @(negedge clk);
        walk = 1'b0;
        respond("flush_wr", 0, 1, 32'h8000_0C02, 32'h0004_048C);
        flush = 1'b1;
        #1;
        chk("flush_wr_wen", {28'd0, wen}, 32'd0);
        chk("flush_wr_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("flush_wr_idle", {31'd0, busy}, 32'd0);

        // asynchronous reset in the middle of an L2 fetch
        @(negedge clk);
        va = 32'h0003_4ABC; walk = 1'b1;
        @(negedge clk);
        walk = 1'b0;
        respond("rst_mid_l1", 0, 1, 32'h0010_0021, 32'h0004_0000);
        @(negedge clk);
        chk("rst_mid_l2_cyc", {31'd0, cyc}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_cyc", {30'd0, cyc, stb}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1]);

        chk("wen_cyc_excl", overlap, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
